// File: rtl/dsw_pkg.sv
// Shared encodings for the dual-slot writer: slot FSM states, select values, timer sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dsw_pkg;

    // Per-slot occupancy state
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Write-stream target select
    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    // Hold timer width: must be able to represent TIMEOUT itself
    function automatic int tmr_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dsw_slot.sv
// One holding slot: captures a word, flags it full until acked or the hold timer expires.
// Latency: write visible one edge after acceptance; release one edge after ack/expiry.
// Backpressure: owner must only assert wr_en while full is low; writes to a full slot are ignored.
module dsw_slot
    import dsw_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             ack,
    output logic             full,
    output logic [WIDTH-1:0] dat,
    output logic             drop
);

    localparam int               TMR_W    = tmr_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    slot_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             at_limit;

    assign at_limit = (tmr_q == TMR_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: ack has priority over expiry, both release the slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (wr_en)            state_d = SLOT_FULL;
            SLOT_FULL:  if (ack || at_limit)  state_d = SLOT_EMPTY;
            default:                          state_d = SLOT_EMPTY;
        endcase
    end

    // FSM outputs: drop only when expiry is not rescued by a same-cycle ack
    always_comb begin
        full = (state_q == SLOT_FULL);
        drop = (state_q == SLOT_FULL) && !ack && at_limit;
    end

    // Hold timer: counts unacked full cycles, sits at zero while empty so a new hold starts clean
    always_comb begin
        tmr_d = '0;
        if ((state_q == SLOT_FULL) && !ack) begin
            tmr_d = tmr_q + TMR_ONE;
        end
    end

    // Data capture: only on a real write into an empty slot; value is kept after release
    always_comb begin
        dat_d = dat_q;
        if ((state_q == SLOT_EMPTY) && wr_en) begin
            dat_d = wr_dat;
        end
    end

    // Timer and data registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q <= '0;
            dat_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            dat_q <= dat_d;
        end
    end

    assign dat = dat_q;

endmodule

// File: rtl/dual_slot_writer.sv
// Steers a valid/ready write stream into slot X or Y and counts slots dropped on hold timeout.
// Latency: accepted write shows cond/data after the accepting edge; ack releases after one edge.
// Backpressure: in_ready follows the selected slot's registered full flag; no same-cycle bypass.
module dual_slot_writer
    import dsw_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             cond1,
    output logic             cond2,
    input  logic             ack_x,
    input  logic             ack_y,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic             wr_x, wr_y;
    logic             drop_x, drop_y;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Ready mux: depends only on select and registered slot state, never on payload
    always_comb begin
        in_ready = (in_sel == SEL_X) ? !cond1 : !cond2;
    end

    // Write-enable decode for the two slots
    always_comb begin
        wr_x = in_valid && in_ready && (in_sel == SEL_X);
        wr_y = in_valid && in_ready && (in_sel == SEL_Y);
    end

    dsw_slot #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_slot_x (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_x),
        .wr_dat (in_data),
        .ack    (ack_x),
        .full   (cond1),
        .dat    (x),
        .drop   (drop_x)
    );

    dsw_slot #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_slot_y (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_y),
        .wr_dat (in_data),
        .ack    (ack_y),
        .full   (cond2),
        .dat    (y),
        .drop   (drop_y)
    );

    // Saturating add of both drop pulses; one extra bit catches overflow
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q}
                   + {{CNT_W{1'b0}}, drop_x}
                   + {{CNT_W{1'b0}}, drop_y};
        drop_cnt_d = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dual_slot_writer.sv
// Bench for dual_slot_writer: directed scenarios then random traffic against a deadline-based model.
// Latency: driver sets inputs 2 time units after each rising edge; monitor samples 1 unit after.
// Backpressure: model decides acceptance from its own slot occupancy, not from the DUT.
module tb_dual_slot_writer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sel   = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic [WIDTH-1:0] x, y;
    logic             cond1, cond2;
    logic             ack_x    = 1'b0;
    logic             ack_y    = 1'b0;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    dual_slot_writer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .x        (x),
        .y        (y),
        .cond1    (cond1),
        .cond2    (cond2),
        .ack_x    (ack_x),
        .ack_y    (ack_y),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             c1;
        logic             c2;
        int               dc;
    } exp_t;

    exp_t exp_q[$];
    logic rdy_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each slot remembers the edge index of its write; it expires
    // exactly TIMEOUT edges later unless acked first.
    bit               m_known = 1'b0;
    bit               m_full[2];
    int               m_wr[2];
    logic [WIDTH-1:0] m_dat[2];
    int               m_drops = 0;
    int               cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the expected response for the coming edge
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [WIDTH-1:0] d, input logic ax, input logic ay);
        exp_t e;
        bit   a;
        @(posedge clk);
        #2;
        rst_n    = r;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        ack_x    = ax;
        ack_y    = ay;
        if (m_known) rdy_q.push_back(s ? !m_full[1] : !m_full[0]);
        if (!r) begin
            m_known  = 1'b1;
            m_full[0] = 1'b0;
            m_full[1] = 1'b0;
            m_dat[0]  = '0;
            m_dat[1]  = '0;
            m_drops   = 0;
        end else if (m_known) begin
            for (int i = 0; i < 2; i++) begin
                a = (i == 0) ? ax : ay;
                if (m_full[i]) begin
                    if (a) begin
                        m_full[i] = 1'b0;
                    end else if (cyc == m_wr[i] + TIMEOUT) begin
                        m_full[i] = 1'b0;
                        if (m_drops < CNT_MAX) m_drops++;
                    end
                end else if (v && (s == i[0])) begin
                    m_full[i] = 1'b1;
                    m_wr[i]   = cyc;
                    m_dat[i]  = d;
                end
            end
        end
        cyc++;
        if (m_known) begin
            e.x  = m_dat[0];
            e.y  = m_dat[1];
            e.c1 = m_full[0];
            e.c2 = m_full[1];
            e.dc = m_drops;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: ready is combinational, so compare it mid-cycle while inputs are stable
    initial begin
        logic r;
        forever begin
            @(negedge clk);
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                chk("in_ready", 32'(in_ready), 32'(r));
            end
        end
    end

    // Monitor: registered outputs compared just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("x",        32'(x),        32'(e.x));
                chk("y",        32'(y),        32'(e.y));
                chk("cond1",    32'(cond1),    32'(e.c1));
                chk("cond2",    32'(cond2),    32'(e.c2));
                chk("drop_cnt", 32'(drop_cnt), e.dc);
            end
        end
    end

    initial begin
        int cnt;
        // Reset
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_drop", 32'(drop_cnt), 32'd0);

        // Single write to X
        step(1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        #1;
        chk("wr_x_cond1", 32'(cond1), 32'd1);
        chk("wr_x_data", 32'(x), 32'h01);
        chk("wr_x_cond2", 32'(cond2), 32'd0);
        chk("wr_x_ready_blocked", 32'(in_ready), 32'd0);

        // Fill Y, release X only, then rewrite X one cycle later
        step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        chk("ack_x_cond1", 32'(cond1), 32'd0);
        chk("ack_x_cond2", 32'(cond2), 32'd1);
        idle();
        chk("rewrite_x", 32'(x), 32'h33);

        // Ack and write to the same full slot in one cycle: freed but not refilled
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        idle();
        chk("no_bypass_cond1", 32'(cond1), 32'd0);
        chk("no_bypass_x", 32'(x), 32'h33);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle();

        // Y held without ack: full for exactly TIMEOUT cycles, then one drop
        step(1'b1, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
        cnt = 0;
        repeat (30) begin
            idle();
            if (cond2) cnt++;
        end
        chk("hold_cycles", cnt, TIMEOUT);
        chk("timeout_drop", 32'(drop_cnt), 32'd1);

        // Ack arriving on the expiry cycle wins
        step(1'b1, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
        repeat (TIMEOUT - 1) idle();
        chk("ack_edge_still_full", 32'(cond1), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("ack_edge_cond1", 32'(cond1), 32'd0);
        chk("ack_edge_no_drop", 32'(drop_cnt), 32'd1);

        // Drive the counter to 2, then two more drops saturate at 3
        step(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (TIMEOUT + 3) idle();
        chk("drop_two", 32'(drop_cnt), 32'd2);
        step(1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
        repeat (TIMEOUT) idle();
        chk("sat_first", 32'(drop_cnt), 32'd3);
        chk("sat_y_still_full", 32'(cond2), 32'd1);
        idle();
        chk("sat_hold", 32'(drop_cnt), 32'd3);
        chk("sat_y_released", 32'(cond2), 32'd0);

        // Reset while X is held, with payload churning underneath
        step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        repeat (5) idle();
        step(1'b0, 1'b0, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
        #1;
        chk("midrst_cond1", 32'(cond1), 32'd0);
        chk("midrst_x", 32'(x), 32'd0);
        chk("midrst_drop", 32'(drop_cnt), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);

        // Random traffic, occasional resets
        repeat (2000) begin
            step(1'($urandom_range(0, 199) != 0),
                 1'($urandom),
                 1'($urandom),
                 WIDTH'($urandom),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0));
        end

        repeat (3) idle();
        @(posedge clk);
        #3;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("rdy_q_drained", rdy_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
